// File: rtl/button_pkg.sv
// Shared types and default thresholds for the button conditioner slice.
// The state enum is common to every debounce channel.
package button_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } btn_state_e;

    localparam int DEFAULT_BUTTONCOUNT      = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES  = 50000;
    localparam int DEFAULT_LONGPRESS_CYCLES = 12000000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: debounce FSM, long-press timer and sticky press flag.
// All outputs are registered.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONGPRESS_CYCLES = DEFAULT_LONGPRESS_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic event_clr,
    output logic buttons,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic event_flag
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int LW = $clog2(LONGPRESS_CYCLES) + 1;
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONGPRESS_CYCLES);
    localparam logic [LW-1:0] LONG_PRE = LW'(LONGPRESS_CYCLES - 1);
    localparam logic [LW-1:0] LONG_ONE = LW'(1);

    btn_state_e      state_r, state_s;
    logic [DW-1:0]   cnt_r, cnt_s;
    logic [LW-1:0]   lcnt_r, lcnt_s;
    logic            buttons_r, buttons_s;
    logic            press_r, press_s;
    logic            release_r, release_s;
    logic            long_r, long_s;
    logic            flag_r, flag_s;
    logic            long_active_s;

    // Debounce next-state: a level change is accepted only after the counter hits the threshold.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        buttons_s = buttons_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        case (state_r)
            STABLE_LO: begin
                if (level) begin
                    state_s = PEND_HI;
                    cnt_s   = DEB_ONE;
                end else begin
                    state_s = STABLE_LO;
                    cnt_s   = {DW{1'b0}};
                end
            end
            PEND_HI: begin
                if (!level) begin
                    state_s = STABLE_LO;
                    cnt_s   = {DW{1'b0}};
                end else if (cnt_r == DEB_MAX) begin
                    state_s   = STABLE_HI;
                    cnt_s     = {DW{1'b0}};
                    buttons_s = 1'b1;
                    press_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + DEB_ONE;
                end
            end
            STABLE_HI: begin
                if (!level) begin
                    state_s = PEND_LO;
                    cnt_s   = DEB_ONE;
                end else begin
                    state_s = STABLE_HI;
                    cnt_s   = {DW{1'b0}};
                end
            end
            PEND_LO: begin
                if (level) begin
                    state_s = STABLE_HI;
                    cnt_s   = {DW{1'b0}};
                end else if (cnt_r == DEB_MAX) begin
                    state_s   = STABLE_LO;
                    cnt_s     = {DW{1'b0}};
                    buttons_s = 1'b0;
                    release_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + DEB_ONE;
                end
            end
            default: begin
                state_s   = STABLE_LO;
                cnt_s     = {DW{1'b0}};
                buttons_s = 1'b0;
            end
        endcase
    end

    // Long-press timer: counts while the debounced level is high, saturates at the threshold.
    always_comb begin
        long_active_s = (state_r == STABLE_HI) || (state_r == PEND_LO);
        if (!long_active_s) begin
            lcnt_s = {LW{1'b0}};
            long_s = 1'b0;
        end else if (lcnt_r != LONG_MAX) begin
            lcnt_s = lcnt_r + LONG_ONE;
            long_s = (lcnt_r == LONG_PRE);
        end else begin
            lcnt_s = lcnt_r;
            long_s = 1'b0;
        end
    end

    // Sticky flag: a press in the same cycle as a clear wins.
    always_comb begin
        flag_s = press_r | (flag_r & ~event_clr);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= STABLE_LO;
            cnt_r     <= {DW{1'b0}};
            lcnt_r    <= {LW{1'b0}};
            buttons_r <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;
            flag_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            lcnt_r    <= lcnt_s;
            buttons_r <= buttons_s;
            press_r   <= press_s;
            release_r <= release_s;
            long_r    <= long_s;
            flag_r    <= flag_s;
        end
    end

    assign buttons       = buttons_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign long_pulse    = long_r;
    assign event_flag    = flag_r;

endmodule

// File: rtl/sync.sv
// Two-flop synchroniser for one asynchronous bit into the clk domain.
module sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Metastability filter: first stage may go metastable, second stage resolves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner top: per-bit synchroniser, optional polarity inversion,
// and one independent debounce channel per button.
module button_conditioner
    import button_pkg::*;
#(
    parameter int BUTTONCOUNT      = DEFAULT_BUTTONCOUNT,
    parameter int DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONGPRESS_CYCLES = DEFAULT_LONGPRESS_CYCLES,
    parameter int ACTIVE_LOW       = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BUTTONCOUNT-1:0] buttons_raw,
    output logic [BUTTONCOUNT-1:0] buttons,
    output logic [BUTTONCOUNT-1:0] press_pulse,
    output logic [BUTTONCOUNT-1:0] release_pulse,
    output logic [BUTTONCOUNT-1:0] long_pulse,
    output logic [BUTTONCOUNT-1:0] event_flags,
    input  logic [BUTTONCOUNT-1:0] event_clr
);

    logic [BUTTONCOUNT-1:0] sync_q_s;
    logic [BUTTONCOUNT-1:0] level_s;

    generate
        for (genvar i = 0; i < BUTTONCOUNT; i++) begin : g_chan
            sync u_sync (
                .clk   (clk),
                .reset (reset),
                .d     (buttons_raw[i]),
                .q     (sync_q_s[i])
            );

            // Inversion sits after the synchroniser so pad polarity never reaches async logic.
            assign level_s[i] = (ACTIVE_LOW != 0) ? ~sync_q_s[i] : sync_q_s[i];

            debounce_channel #(
                .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
                .LONGPRESS_CYCLES (LONGPRESS_CYCLES)
            ) u_chan (
                .clk           (clk),
                .reset         (reset),
                .level         (level_s[i]),
                .event_clr     (event_clr[i]),
                .buttons       (buttons[i]),
                .press_pulse   (press_pulse[i]),
                .release_pulse (release_pulse[i]),
                .long_pulse    (long_pulse[i]),
                .event_flag    (event_flags[i])
            );
        end
    endgenerate

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter BUTTONCOUNT, default 4, number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a level change (legal range 2..65535).
REQ-003 Parameter LONGPRESS_CYCLES, default 12000000, cycles a debounced press must persist to raise a long-press event (must exceed DEBOUNCE_CYCLES).
REQ-004 Parameter ACTIVE_LOW, default 0; when 1, raw inputs are inverted immediately after synchronisation.
REQ-005 clk  input  1  single clock, the PLL output clock domain.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 buttons_raw  input  BUTTONCOUNT  asynchronous pad inputs.
REQ-008 buttons  output  BUTTONCOUNT  debounced level, 1 = pressed; drives the SoC buttons port.
REQ-009 press_pulse  output  BUTTONCOUNT  one-cycle strobe on accepted press.
REQ-010 release_pulse  output  BUTTONCOUNT  one-cycle strobe on accepted release.
REQ-011 long_pulse  output  BUTTONCOUNT  one-cycle strobe when long-press threshold is reached.
REQ-012 event_flags  output  BUTTONCOUNT  sticky press-event flags.
REQ-013 event_clr  input  BUTTONCOUNT  write-1-to-clear strobe for event_flags.

Function
REQ-014 Each raw bit SHALL pass through a 2-flop synchroniser before any other logic, followed by optional inversion per ACTIVE_LOW.
REQ-015 Each channel SHALL run a 4-state FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-016 STABLE_LO -> PEND_HI when the synchronised level is 1; the debounce counter loads 1.
REQ-017 In PEND_HI, counter increments while the level is 1; a 0 returns to STABLE_LO with the counter cleared and no output change.
REQ-018 PEND_HI -> STABLE_HI when the counter equals DEBOUNCE_CYCLES; buttons[i] goes to 1 and press_pulse[i] asserts for exactly that cycle.
REQ-019 STABLE_HI, PEND_LO, release_pulse[i] and buttons[i] going to 0 are the exact mirror of REQ-016..REQ-018.
REQ-020 Latency: for a raw edge held stable, buttons[i] changes exactly 2 + DEBOUNCE_CYCLES cycles after the first clk edge that samples the new raw level.
REQ-021 A glitch lasting fewer than DEBOUNCE_CYCLES synchronised cycles SHALL produce no change on any output.
REQ-022 The long-press counter runs while the channel is in STABLE_HI or PEND_LO; it clears on entering STABLE_LO; it saturates at LONGPRESS_CYCLES.
REQ-023 long_pulse[i] asserts for one cycle when the long-press counter first reaches LONGPRESS_CYCLES, at most once per press.
REQ-024 event_flags[i] sets on press_pulse[i] and clears on event_clr[i]; a simultaneous set and clear SHALL leave the flag set.
REQ-025 Counter widths SHALL be $clog2 of their threshold plus 1, so no counter can wrap.
REQ-026 Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.

Reset
REQ-027 Reset SHALL asynchronously force all synchroniser flops, counters and outputs to 0, and force every FSM to STABLE_LO.
REQ-028 A button held across reset deassertion SHALL produce press_pulse 2 + DEBOUNCE_CYCLES cycles after the first sampling edge following reset release.
REQ-029 Reset asserted mid-debounce or mid-long-press SHALL discard the pending event without emitting any pulse.

Structure
REQ-030 Shared package button_pkg SHALL hold the FSM state enum typedef and the default threshold constants.
REQ-031 Per-channel logic SHALL be one sub-module, debounce_channel, instantiated BUTTONCOUNT times via generate.
REQ-032 The synchroniser SHALL reuse the existing sync module, one instance per bit.

Verification (DEBOUNCE_CYCLES=8, LONGPRESS_CYCLES=32, BUTTONCOUNT=4)
REQ-033 Raw[0] rises at cycle 0 and is held -> buttons[0]=1 and press_pulse[0]=1 at cycle 10 only, and event_flags[0]=1 from cycle 11.
REQ-034 Raw[1] gets a 5-cycle high glitch -> buttons, press_pulse and event_flags stay 0 for channel 1.
REQ-035 Raw[2] is held high for 60 cycles -> long_pulse[2] pulses once, 32 cycles after press_pulse[2]; release_pulse[2] follows the release by 10 cycles.
REQ-036 event_clr[0] is asserted in the same cycle as a new press_pulse[0] -> event_flags[0] remains 1; event_clr[0] alone on a later cycle -> 0 on the next cycle.
REQ-037 Reset is asserted at cycle 5 of a pending press, with the raw level still held -> no pulse during reset; press_pulse reasserts 10 cycles after reset release.
REQ-038 All 4 raw inputs rise in the same cycle -> press_pulse=4'b1111 in a single cycle.
